// File: rtl/rf_pkg.sv
// rf_pkg: shared types and helpers for the multi-port register file.
//   rf_state_e   clear-engine state (RF_CLEAR, RF_READY)
//   RF_ZERO_ADDR address of the hardwired-zero entry when enabled
//   slice_lo     low bit of element idx in a packed vector of width-bit fields
package rf_pkg;

  typedef enum logic {
    RF_CLEAR = 1'b0,
    RF_READY = 1'b1
  } rf_state_e;

  localparam int RF_ZERO_ADDR = 0;

  function automatic int slice_lo(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

// File: rtl/rf_multiport_if.sv
// rf_multiport_if: decode/writeback side bundle of the register file.
//   rd_addr/rd_data/rd_busy    NRD packed read ports (data and busy combinational)
//   wr_en/wr_addr/wr_data      NWR packed write ports, higher index wins
//   issue_en/issue_addr        destination issued -> mark busy
//   clr_req                    restart the sequential clear
//   init_done                  file usable
// master = pipeline side, slave = register file.
interface rf_multiport_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NRD    = 2,
  parameter int NWR    = 2
);
  logic [NRD*ADDR_W-1:0] rd_addr;
  logic [NRD*DATA_W-1:0] rd_data;
  logic [NRD-1:0]        rd_busy;
  logic [NWR-1:0]        wr_en;
  logic [NWR*ADDR_W-1:0] wr_addr;
  logic [NWR*DATA_W-1:0] wr_data;
  logic                  issue_en;
  logic [ADDR_W-1:0]     issue_addr;
  logic                  clr_req;
  logic                  init_done;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, issue_en, issue_addr, clr_req,
    input  rd_data, rd_busy, init_done
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, issue_en, issue_addr, clr_req,
    output rd_data, rd_busy, init_done
  );
endinterface

// File: rtl/rf_scoreboard.sv
// rf_scoreboard: per-entry busy bits for hazard detection.
//   clk, rst      clock, async active-low reset (busy all 0)
//   ready         file in READY; issue is ignored otherwise
//   clr_en/clr_idx  clear engine strobe and the entry it clears this edge
//   wr_hit        one bit per entry: an effective write targets it this cycle
//   issue_en/issue_addr  destination being issued
//   rd_addr/rd_busy      packed read addresses and their busy flags
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int ADDR_W   = 5,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ready,
  input  logic                    clr_en,
  input  logic [ADDR_W-1:0]       clr_idx,
  input  logic [(2**ADDR_W)-1:0]  wr_hit,
  input  logic                    issue_en,
  input  logic [ADDR_W-1:0]       issue_addr,
  input  logic [NRD*ADDR_W-1:0]   rd_addr,
  output logic [NRD-1:0]          rd_busy
);
  localparam int NREG = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] ZADDR = ADDR_W'(RF_ZERO_ADDR);

  logic [NREG-1:0]   busy_q, busy_d;
  logic              issue_ok;
  logic [ADDR_W-1:0] rd_a [NRD];

  assign issue_ok = ready && issue_en && !(ZERO_REG != 0 && issue_addr == ZADDR);

  // Issue is applied after the write clear so a same-cycle new producer keeps the entry busy.
  always_comb begin
    busy_d = busy_q;
    if (clr_en) busy_d[clr_idx] = 1'b0;
    busy_d = busy_d & ~wr_hit;
    if (issue_ok) busy_d[issue_addr] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) busy_q <= '0;
    else      busy_q <= busy_d;
  end

  always_comb begin
    for (int i = 0; i < NRD; i++) rd_a[i] = rd_addr[slice_lo(i, ADDR_W) +: ADDR_W];
  end

  // A write landing this cycle already satisfies the consumer.
  always_comb begin
    rd_busy = '0;
    for (int i = 0; i < NRD; i++) begin
      rd_busy[i] = ready && busy_q[rd_a[i]] && !wr_hit[rd_a[i]] &&
                   !(ZERO_REG != 0 && rd_a[i] == ZADDR);
    end
  end

endmodule

// File: rtl/rf_multiport.sv
// rf_multiport: parametrised multi-port integer register file with busy scoreboard
// and a sequential clear engine (storage itself has no reset).
//   clk  clock, all updates on rising edge
//   rst  async active-low reset, enters CLEAR with counter 0
//   bus  rf_multiport_if slave: read/write/issue ports, clr_req, init_done
//
// state    | meaning
// RF_CLEAR | one entry zeroed per edge, ports ignored, reads return 0
// RF_READY | normal operation, clr_req restarts the clear
module rf_multiport
  import rf_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NRD      = 2,
  parameter int NWR      = 2,
  parameter int ZERO_REG = 1
) (
  input  logic          clk,
  input  logic          rst,
  rf_multiport_if.slave bus
);
  localparam int NREG = 2**ADDR_W;
  localparam logic [ADDR_W:0]   CNT_LAST = (ADDR_W+1)'(NREG - 1);
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] ZADDR    = ADDR_W'(RF_ZERO_ADDR);

  rf_state_e state_q, state_d;
  logic [ADDR_W:0] cnt_q, cnt_d;
  logic ready, clr_en;

  logic [ADDR_W-1:0] wr_a [NWR];
  logic [DATA_W-1:0] wr_d [NWR];
  logic [ADDR_W-1:0] rd_a [NRD];
  logic [NWR-1:0]    wr_eff;
  logic [NREG-1:0]   wr_hit;
  logic [NREG-1:0]   ent_we;
  logic [DATA_W-1:0] ent_wd [NREG];
  logic [DATA_W-1:0] mem    [NREG];
  logic [NRD*DATA_W-1:0] rd_data;
  logic [NRD-1:0]        rd_busy;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RF_CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Counter is one bit wider than an address so it parks at NREG instead of wrapping.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      RF_CLEAR: begin
        cnt_d = cnt_q + CNT_ONE;
        if (cnt_q == CNT_LAST) state_d = RF_READY;
      end
      RF_READY: begin
        if (bus.clr_req) begin
          state_d = RF_CLEAR;
          cnt_d   = '0;
        end
      end
    endcase
  end

  assign ready         = (state_q == RF_READY);
  assign clr_en        = (state_q == RF_CLEAR);
  assign bus.init_done = ready;

  always_comb begin
    for (int j = 0; j < NWR; j++) begin
      wr_a[j] = bus.wr_addr[slice_lo(j, ADDR_W) +: ADDR_W];
      wr_d[j] = bus.wr_data[slice_lo(j, DATA_W) +: DATA_W];
    end
    for (int i = 0; i < NRD; i++) rd_a[i] = bus.rd_addr[slice_lo(i, ADDR_W) +: ADDR_W];
  end

  // Writes only count in READY; that keeps CLEAR from being disturbed by the pipeline.
  always_comb begin
    for (int j = 0; j < NWR; j++) begin
      wr_eff[j] = ready && bus.wr_en[j] && !(ZERO_REG != 0 && wr_a[j] == ZADDR);
    end
  end

  // Ascending port order: a later (higher) port overwrites an earlier one on the same entry.
  always_comb begin
    wr_hit = '0;
    ent_we = '0;
    for (int e = 0; e < NREG; e++) ent_wd[e] = '0;
    if (clr_en) ent_we[cnt_q[ADDR_W-1:0]] = 1'b1;
    for (int j = 0; j < NWR; j++) begin
      if (wr_eff[j]) begin
        wr_hit[wr_a[j]] = 1'b1;
        ent_we[wr_a[j]] = 1'b1;
        ent_wd[wr_a[j]] = wr_d[j];
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int e = 0; e < NREG; e++) begin
      if (ent_we[e]) mem[e] <= ent_wd[e];
    end
  end

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NRD; i++) begin
      if (ready && !(ZERO_REG != 0 && rd_a[i] == ZADDR)) begin
        rd_data[slice_lo(i, DATA_W) +: DATA_W] = mem[rd_a[i]];
        for (int j = 0; j < NWR; j++) begin
          if (wr_eff[j] && wr_a[j] == rd_a[i])
            rd_data[slice_lo(i, DATA_W) +: DATA_W] = wr_d[j];
        end
      end
    end
  end

  rf_scoreboard #(
    .ADDR_W   (ADDR_W),
    .NRD      (NRD),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk        (clk),
    .rst        (rst),
    .ready      (ready),
    .clr_en     (clr_en),
    .clr_idx    (cnt_q[ADDR_W-1:0]),
    .wr_hit     (wr_hit),
    .issue_en   (bus.issue_en),
    .issue_addr (bus.issue_addr),
    .rd_addr    (bus.rd_addr),
    .rd_busy    (rd_busy)
  );

  assign bus.rd_data = rd_data;
  assign bus.rd_busy = rd_busy;

endmodule
